// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, combinational imem address, fetch/decode pipeline register.
// Optional build macro FETCH_JUMP_EN folds PC-relative jumps into the next-PC choice.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'd0,
    parameter logic [5:0]  OPC_HALT = 6'b100100,
    parameter logic [5:0]  OPC_JUMP = 6'b100000
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_ins,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_ins,
    output logic [31:0] if_pc,
    output logic        halted,
    output logic [1:0]  state_dbg
);

    typedef enum logic [1:0] {RUN = 2'd0, HALT = 2'd1, DONE = 2'd2} state_t;

    state_t      state, state_n;
    logic [31:0] pc, pc_n;
    logic [31:0] if_ins_n, if_pc_n;
    logic        if_valid_n;
    logic        load;
    logic        is_halt;
    logic [31:0] pc_seq;

    // Handshake: a transfer happens when if_valid && if_ready; the register may
    // be reloaded whenever it is empty or being drained (!if_valid || if_ready).
    assign load      = !if_valid || if_ready;
    assign is_halt   = (imem_ins[31:26] == OPC_HALT);
    assign imem_addr = pc;
    assign halted    = (state == DONE);
    assign state_dbg = state;

`ifdef FETCH_JUMP_EN
    always_comb begin
        pc_seq = pc + 32'd1;
        if (imem_ins[31:26] == OPC_JUMP)
            pc_seq = pc + {{6{imem_ins[25]}}, imem_ins[25:0]};
    end
`else
    logic unused_jump;
    assign unused_jump = ^OPC_JUMP;
    assign pc_seq      = pc + 32'd1;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= RUN;
            pc       <= RESET_PC;
            if_valid <= 1'b0;
            if_ins   <= 32'd0;
            if_pc    <= 32'd0;
        end else begin
            state    <= state_n;
            pc       <= pc_n;
            if_valid <= if_valid_n;
            if_ins   <= if_ins_n;
            if_pc    <= if_pc_n;
        end
    end

    always_comb begin
        state_n    = state;
        pc_n       = pc;
        if_valid_n = if_valid;
        if_ins_n   = if_ins;
        if_pc_n    = if_pc;
        // Redirect wins everywhere and squashes whatever sits in the register.
        if (redirect_valid) begin
            pc_n       = redirect_pc;
            if_valid_n = 1'b0;
            state_n    = RUN;
        end else begin
            case (state)
                RUN: begin
                    if (load) begin
                        if_ins_n   = imem_ins;
                        if_pc_n    = pc;
                        if_valid_n = 1'b1;
                        if (is_halt) state_n = HALT;
                        else         pc_n    = pc_seq;
                    end
                end
                HALT: begin
                    if (if_valid && if_ready) begin
                        if_valid_n = 1'b0;
                        state_n    = DONE;
                    end
                end
                DONE: begin
                    if_valid_n = 1'b0;
                end
                default: begin
                    state_n    = RUN;
                    if_valid_n = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed program walk followed by randomized ready/redirect traffic,
// every cycle compared against a transaction-level reference model.
module tb_fetch_stage;

    localparam logic [31:0] RESET_PC = 32'd0;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] imem_addr;
    logic [31:0] imem_ins;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'd0;
    logic        if_valid;
    logic        if_ready = 1'b0;
    logic [31:0] if_ins;
    logic [31:0] if_pc;
    logic        halted;
    logic [1:0]  state_dbg;

    int vectors = 0;
    int errors  = 0;

    logic [31:0] mem [16];
    assign imem_ins = mem[imem_addr[3:0]];

    // clock/reset block
    always #5 clk = ~clk;

    fetch_stage dut (
        .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_ins(imem_ins),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .if_valid(if_valid), .if_ready(if_ready), .if_ins(if_ins), .if_pc(if_pc),
        .halted(halted), .state_dbg(state_dbg)
    );

    // reference model: next fetch address, presented instruction, halt bookkeeping
    logic [31:0] m_pc;
    logic        m_valid;
    logic [31:0] m_ins;
    logic [31:0] m_ipc;
    logic        m_halt_held;
    logic        m_done;

    function automatic bit jump_enabled();
`ifdef FETCH_JUMP_EN
        return 1'b1;
`else
        return 1'b0;
`endif
    endfunction

    task automatic model_reset();
        m_pc = RESET_PC; m_valid = 0; m_ins = 0; m_ipc = 0; m_halt_held = 0; m_done = 0;
    endtask

    task automatic model_step();
        logic [31:0] w;
        int          op;
        int          off;
        if (!rst) begin
            model_reset();
        end else if (redirect_valid) begin
            m_pc = redirect_pc; m_valid = 0; m_halt_held = 0; m_done = 0;
        end else if (m_done) begin
            m_valid = 0;
        end else if (m_halt_held) begin
            if (if_ready) begin m_valid = 0; m_halt_held = 0; m_done = 1; end
        end else if (!m_valid || if_ready) begin
            w = mem[m_pc % 16];
            op = int'(w >> 26);
            m_ins = w; m_ipc = m_pc; m_valid = 1;
            if (op == 36) m_halt_held = 1;
            else if (jump_enabled() && op == 32) begin
                off = (w[25] ? int'(w[25:0]) - (1 << 26) : int'(w[25:0]));
                m_pc = m_pc + 32'(off);
            end else m_pc = m_pc + 1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("imem_addr", imem_addr, m_pc);
        chk("if_valid", 32'(if_valid), 32'(m_valid));
        chk("halted", 32'(halted), 32'(m_done));
        if (m_valid) begin
            chk("if_ins", if_ins, m_ins);
            chk("if_pc", if_pc, m_ipc);
        end
    endtask

    // one clock: model advances with the inputs seen before the edge, then compare
    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic drive(input logic rdy, input logic rv, input logic [31:0] rpc);
        if_ready = rdy; redirect_valid = rv; redirect_pc = rpc;
    endtask

    function automatic logic [31:0] rand_word();
        case ($urandom_range(0, 9))
            0:       return {6'b100100, 26'($urandom)};
            1, 2:    return {6'b100000, 26'($urandom_range(0, 31)) - 26'd16};
            default: return {6'($urandom_range(0, 31)), 26'($urandom)};
        endcase
    endfunction

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 32'd0;
        mem[0] = 32'h44010000; mem[1] = 32'h8C200004; mem[2] = 32'h00411001;
        mem[3] = 32'h08210001; mem[4] = 32'h83FFFFFD; mem[5] = 32'h90000000;
        model_reset();

        // reset held for two cycles
        drive(1, 0, 0);
        tick(); tick();
        chk("reset_if_ins", if_ins, 32'd0);
        chk("reset_if_pc", if_pc, 32'd0);
        @(negedge clk); rst = 1'b1;

        // free run: if_pc 0,1,2
        tick(); chk("first_ins", if_ins, 32'h44010000);
        tick(); tick();
        chk("run_pc2", if_pc, 32'd2);

        // backpressure for three cycles at if_pc=2
        drive(0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("bp_pc", if_pc, 32'd2);
            chk("bp_addr", imem_addr, 32'd3);
        end
        drive(1, 0, 0);
        tick(); chk("bp_release", if_pc, 32'd3);

        // redirect squash while if_pc=3
        drive(1, 1, 32'd5);
        tick(); chk("squash_valid", 32'(if_valid), 32'd0);
        // halt fetched with decode stalled
        drive(0, 0, 0);
        tick(); chk("halt_ins", if_ins, 32'h90000000);
        tick(); chk("halt_addr", imem_addr, 32'd5);
        drive(1, 0, 0);
        tick(); chk("halted", 32'(halted), 32'd1);
        for (int i = 0; i < 10; i++) tick();

        // restart from 0 and walk into the jump at 4
        drive(1, 1, 32'd0);
        tick(); chk("restart_halted", 32'(halted), 32'd0);
        drive(1, 0, 0);
        for (int i = 0; i < 5; i++) tick();
        chk("jump_pc", if_pc, 32'd4);
        chk("jump_next", imem_addr, jump_enabled() ? 32'd1 : 32'd5);
        tick();
        chk("after_jump", if_pc, jump_enabled() ? 32'd1 : 32'd5);

        // pc wraps modulo 2^32
        drive(1, 1, 32'hFFFF_FFFF);
        tick();
        drive(1, 0, 0);
        tick(); chk("wrap_pc", if_pc, 32'hFFFF_FFFF);
        chk("wrap_addr", imem_addr, 32'd0);

        // asynchronous reset between edges
        tick();
        @(posedge clk); model_step(); #1; check_all();
        #2 rst = 1'b0; model_reset();
        #1;
        chk("async_valid", 32'(if_valid), 32'd0);
        chk("async_ins", if_ins, 32'd0);
        chk("async_pc", if_pc, 32'd0);
        chk("async_addr", imem_addr, RESET_PC);
        chk("async_halted", 32'(halted), 32'd0);
        @(negedge clk); rst = 1'b1;

        // randomized program and traffic
        for (int i = 0; i < 16; i++) mem[i] = rand_word();
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 9) == 0)
                drive($urandom_range(0, 9) < 7, 1,
                      ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 + 32'($urandom_range(0, 15))
                                                  : 32'($urandom_range(0, 15)));
            else
                drive($urandom_range(0, 9) < 7, 0, 32'($urandom));
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
